// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, flit-type bit positions and the
// output-port arbiter state encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    // Bit positions inside the 2-bit flit-type field carried with each flit
    localparam int FT_HEAD_BIT = 0;
    localparam int FT_TAIL_BIT = 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of the eligible mask scanning
// ptr+1, ptr+2, ... modulo N.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/out_port_arb.sv
// Output-port arbiter: round-robin packet-level grant with wormhole locking,
// registered link output and downstream credit tracking.
module out_port_arb
    import noc_pkg::*;
#(
    parameter int NUM_IN  = NUM_PORTS,
    parameter int DATA_W  = 32,
    parameter int CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN-1:0]          req_i,
    input  logic [NUM_IN-1:0]          head_i,
    input  logic [NUM_IN-1:0]          tail_i,
    input  logic [NUM_IN*DATA_W-1:0]   flit_i,
    output logic [NUM_IN-1:0]          pop_o,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          flit_o,
    input  logic                       credit_i,
    output logic [$clog2(CREDITS+1)-1:0] credit_o,
    output logic                       err_o
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  ptr, owner, win_idx, pick_idx;
    logic [NUM_IN-1:0] eligible, pick_oh;
    logic [CNT_W-1:0]  credit;
    logic              grant, win_tail, err;
    logic              vld_p1;
    logic [DATA_W-1:0] flit_p1;
    logic [DATA_W-1:0] flit_arr [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign flit_arr[g] = flit_i[g*DATA_W +: DATA_W];
    end

    assign eligible = req_i & head_i;

    rr_pick #(.N(NUM_IN), .IW(IDX_W)) u_rr_pick (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win_idx   = owner;
        pop_o     = '0;
        case (state)
            IDLE: begin
                if (rst_n && credit != '0 && |eligible) begin
                    grant   = 1'b1;
                    win_idx = pick_idx;
                    pop_o   = pick_oh;
                    if (!tail_i[pick_idx]) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                // Only the owner may advance; a head flag here is plain payload
                if (rst_n && credit != '0 && req_i[owner]) begin
                    grant        = 1'b1;
                    pop_o[owner] = 1'b1;
                    if (tail_i[owner]) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign win_tail = tail_i[win_idx];

    // Stage p1: link register, arbitration state and credit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= IDX_W'(NUM_IN - 1);
            owner   <= '0;
            credit  <= CNT_W'(CREDITS);
            err     <= 1'b0;
            vld_p1  <= 1'b0;
            flit_p1 <= '0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= grant;
            if (grant) begin
                flit_p1 <= flit_arr[win_idx];
                if (win_tail)
                    ptr <= win_idx;
                else if (state == IDLE)
                    owner <= win_idx;
            end
            case ({grant, credit_i})
                2'b10: credit <= credit - CNT_W'(1);
                2'b01: begin
                    if (credit == CNT_W'(CREDITS))
                        err <= 1'b1;
                    else
                        credit <= credit + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign valid_o  = vld_p1;
    assign flit_o   = flit_p1;
    assign credit_o = credit;
    assign err_o    = err;

endmodule

// File: tb/tb_out_port_arb.sv
// Directed bench for out_port_arb: round-robin, wormhole locking, credits,
// owner stall and mid-packet reset.
module tb_out_port_arb;

    localparam int NI = 5;
    localparam int DW = 32;

    logic           clk;
    logic           rst_n;
    logic [NI-1:0]  req_i, head_i, tail_i, pop_o;
    logic [NI*DW-1:0] flit_i;
    logic           valid_o;
    logic [DW-1:0]  flit_o;
    logic           credit_i;
    logic [2:0]     credit_o;
    logic           err_o;

    int n_checks = 0;
    int n_fail   = 0;

    out_port_arb #(.NUM_IN(NI), .DATA_W(DW), .CREDITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .head_i   (head_i),
        .tail_i   (tail_i),
        .flit_i   (flit_i),
        .pop_o    (pop_o),
        .valid_o  (valid_o),
        .flit_o   (flit_o),
        .credit_i (credit_i),
        .credit_o (credit_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fval(input int q, input int k);
        return 32'hF000_0000 | DW'(q << 8) | DW'(k);
    endfunction

    task automatic set_flits(input int k);
        for (int q = 0; q < NI; q++) flit_i[q*DW +: DW] = fval(q, k);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_i = '0; head_i = '0; tail_i = '0; credit_i = 1'b0;
        set_flits(0);
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = '1; head_i = '1; tail_i = '1; credit_i = 1'b0;
        set_flits(7);
        #1;
        n_checks++;
        if (pop_o !== 5'b0) begin n_fail++; $display("FAIL reset_pop: got %b expected 00000", pop_o); end
        cyc();
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++;
        if (flit_o !== 32'h0) begin n_fail++; $display("FAIL reset_flit: got %h expected 0", flit_o); end
        n_checks++;
        if (credit_o !== 3'd4) begin n_fail++; $display("FAIL reset_credit: got %0d expected 4", credit_o); end
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
        rst_n = 1'b1; req_i = '0; head_i = '0; tail_i = '0;
    endtask

    task automatic test_round_robin();
        logic [NI-1:0] exp_pop [5] = '{5'b00001, 5'b10000, 5'b00001, 5'b10000, 5'b00000};
        int            exp_q   [5] = '{0, 4, 0, 4, 4};
        logic [2:0]    exp_cr  [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        do_reset();
        req_i = 5'b10001; head_i = 5'b10001; tail_i = 5'b10001;
        for (int k = 0; k < 5; k++) begin
            set_flits(k);
            #1;
            n_checks++;
            if (pop_o !== exp_pop[k]) begin n_fail++; $display("FAIL rr_pop[%0d]: got %b expected %b", k, pop_o, exp_pop[k]); end
            cyc();
            n_checks++;
            if (valid_o !== (exp_pop[k] != 0)) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected %b", k, valid_o, exp_pop[k] != 0); end
            n_checks++;
            if (flit_o !== fval(exp_q[k], (k < 4) ? k : 3)) begin n_fail++; $display("FAIL rr_flit[%0d]: got %h expected %h", k, flit_o, fval(exp_q[k], (k < 4) ? k : 3)); end
            n_checks++;
            if (credit_o !== exp_cr[k]) begin n_fail++; $display("FAIL rr_credit[%0d]: got %0d expected %0d", k, credit_o, exp_cr[k]); end
        end
        // One returned credit buys exactly one more pop
        credit_i = 1'b1;
        #1;
        n_checks++;
        if (pop_o !== 5'b0) begin n_fail++; $display("FAIL rr_nocredit_pop: got %b expected 00000", pop_o); end
        cyc();
        credit_i = 1'b0;
        n_checks++;
        if (credit_o !== 3'd1) begin n_fail++; $display("FAIL rr_credit_ret: got %0d expected 1", credit_o); end
        #1;
        n_checks++;
        if (pop_o !== 5'b00001) begin n_fail++; $display("FAIL rr_extra_pop: got %b expected 00001", pop_o); end
        cyc();
        #1;
        n_checks++;
        if (pop_o !== 5'b0) begin n_fail++; $display("FAIL rr_after_extra: got %b expected 00000", pop_o); end
        n_checks++;
        if (credit_o !== 3'd0) begin n_fail++; $display("FAIL rr_credit_end: got %0d expected 0", credit_o); end
        req_i = '0; head_i = '0; tail_i = '0;
    endtask

    task automatic test_wormhole();
        logic [NI-1:0] rq [5] = '{5'b00100, 5'b00110, 5'b00110, 5'b00010, 5'b00000};
        logic [NI-1:0] hd [5] = '{5'b00100, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
        logic [NI-1:0] tl [5] = '{5'b00000, 5'b00000, 5'b00100, 5'b00010, 5'b00000};
        logic [NI-1:0] ep [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00010, 5'b00000};
        int            eq [5] = '{2, 2, 2, 1, 1};
        int vcount = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req_i = rq[k]; head_i = hd[k]; tail_i = tl[k];
            set_flits(10 + k);
            #1;
            n_checks++;
            if (pop_o !== ep[k]) begin n_fail++; $display("FAIL wh_pop[%0d]: got %b expected %b", k, pop_o, ep[k]); end
            cyc();
            if (valid_o === 1'b1) vcount++;
            n_checks++;
            if (flit_o !== fval(eq[k], (k < 4) ? 10 + k : 13)) begin n_fail++; $display("FAIL wh_flit[%0d]: got %h expected %h", k, flit_o, fval(eq[k], (k < 4) ? 10 + k : 13)); end
        end
        n_checks++;
        if (vcount !== 4) begin n_fail++; $display("FAIL wh_valid_count: got %0d expected 4", vcount); end
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL wh_valid_end: got %b expected 0", valid_o); end
    endtask

    task automatic test_credit();
        do_reset();
        req_i = 5'b00001; head_i = 5'b00001; tail_i = 5'b00001;
        cyc();
        cyc();
        n_checks++;
        if (credit_o !== 3'd2) begin n_fail++; $display("FAIL cr_two_pops: got %0d expected 2", credit_o); end
        credit_i = 1'b1;
        #1;
        n_checks++;
        if (pop_o !== 5'b00001) begin n_fail++; $display("FAIL cr_pop_with_credit: got %b expected 00001", pop_o); end
        cyc();
        n_checks++;
        if (credit_o !== 3'd2) begin n_fail++; $display("FAIL cr_both: got %0d expected 2", credit_o); end
        req_i = '0;
        cyc();
        cyc();
        n_checks++;
        if (credit_o !== 3'd4 || err_o !== 1'b0) begin n_fail++; $display("FAIL cr_refill: got %0d/%b expected 4/0", credit_o, err_o); end
        cyc();
        n_checks++;
        if (credit_o !== 3'd4 || err_o !== 1'b1) begin n_fail++; $display("FAIL cr_overflow: got %0d/%b expected 4/1", credit_o, err_o); end
        credit_i = 1'b0;
        req_i = 5'b00001;
        cyc();
        req_i = '0;
        cyc();
        n_checks++;
        if (credit_o !== 3'd3 || err_o !== 1'b1) begin n_fail++; $display("FAIL cr_err_sticky: got %0d/%b expected 3/1", credit_o, err_o); end
    endtask

    task automatic test_owner_stall();
        logic [NI-1:0] rq [6] = '{5'b01000, 5'b00001, 5'b00001, 5'b01001, 5'b00001, 5'b00000};
        logic [NI-1:0] hd [6] = '{5'b01000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
        logic [NI-1:0] tl [6] = '{5'b00000, 5'b00001, 5'b00001, 5'b01001, 5'b00001, 5'b00000};
        logic [NI-1:0] ep [6] = '{5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b00001, 5'b00000};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req_i = rq[k]; head_i = hd[k]; tail_i = tl[k];
            set_flits(20 + k);
            #1;
            n_checks++;
            if (pop_o !== ep[k]) begin n_fail++; $display("FAIL stall_pop[%0d]: got %b expected %b", k, pop_o, ep[k]); end
            cyc();
            n_checks++;
            if (valid_o !== (ep[k] != 0)) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected %b", k, valid_o, ep[k] != 0); end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_i = 5'b00100; head_i = 5'b00100; tail_i = 5'b00000;
        set_flits(30);
        #1;
        n_checks++;
        if (pop_o !== 5'b00100) begin n_fail++; $display("FAIL mid_head_pop: got %b expected 00100", pop_o); end
        cyc();
        rst_n = 1'b0; head_i = 5'b00000;
        #1;
        n_checks++;
        if (pop_o !== 5'b0) begin n_fail++; $display("FAIL mid_rst_pop: got %b expected 00000", pop_o); end
        cyc();
        n_checks++;
        if (valid_o !== 1'b0 || credit_o !== 3'd4 || flit_o !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst_state: got v=%b c=%0d f=%h expected v=0 c=4 f=0", valid_o, credit_o, flit_o);
        end
        rst_n = 1'b1; req_i = 5'b00101; head_i = 5'b00001; tail_i = 5'b00001;
        set_flits(31);
        #1;
        n_checks++;
        if (pop_o !== 5'b00001) begin n_fail++; $display("FAIL mid_new_head: got %b expected 00001", pop_o); end
        cyc();
        n_checks++;
        if (valid_o !== 1'b1 || flit_o !== fval(0, 31)) begin n_fail++; $display("FAIL mid_new_flit: got %b/%h expected 1/%h", valid_o, flit_o, fval(0, 31)); end
        req_i = 5'b00100; head_i = 5'b00000; tail_i = 5'b00000;
        #1;
        n_checks++;
        if (pop_o !== 5'b0) begin n_fail++; $display("FAIL mid_body_ignored: got %b expected 00000", pop_o); end
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; req_i = '0; head_i = '0; tail_i = '0; credit_i = 1'b0;
        flit_i = '0;
        cyc();
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit();
        test_owner_stall();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
